// File: rtl/button_events.sv
// ============================================================================
//  Module      : button_events
//  Description : Turns a debounced button level into one-cycle short-press,
//                long-press and auto-repeat pulses, plus a "press tracked"
//                level for the time-setting logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_events #(
   parameter int LONG_TICKS   = 12500,
   parameter int REPEAT_TICKS = 2500,
   parameter int CNT_W        = 14
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_short,
   output logic o_long,
   output logic o_repeat,
   output logic o_held
);

   typedef enum logic [1:0] {
      S_LOCKOUT = 2'd0,
      S_IDLE    = 2'd1,
      S_SHORT   = 2'd2,
      S_REPEAT  = 2'd3
   } state_t;

   // Match points at which the hold/repeat counter is reloaded to zero.
   localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] c_CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             short_q, short_d;
   logic             long_q,  long_d;
   logic             rep_q,   rep_d;
   logic             held_q,  held_d;

   // State, counter and registered pulse outputs; reset lands in LOCKOUT so a
   // button held through reset is ignored until it is released.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_LOCKOUT;
         cnt_q   <= c_CNT_ZERO;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         short_q <= short_d;
         long_q  <= long_d;
         rep_q   <= rep_d;
         held_q  <= held_d;
      end
   end

   // Next-state, counter and pulse decode; release is tested before the
   // threshold so a release on the threshold sample still counts as short.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;

      case (state_q)
         S_LOCKOUT: begin
            if (!i_btn) begin
               state_d = S_IDLE;
               cnt_d   = c_CNT_ZERO;
            end
         end

         S_IDLE: begin
            if (i_btn) begin
               state_d = S_SHORT;
               cnt_d   = c_CNT_ONE;
            end
         end

         S_SHORT: begin
            if (!i_btn) begin
               short_d = 1'b1;
               state_d = S_IDLE;
               cnt_d   = c_CNT_ZERO;
            end else if (cnt_q == c_LONG_LAST) begin
               long_d  = 1'b1;
               state_d = S_REPEAT;
               cnt_d   = c_CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + c_CNT_ONE;
            end
         end

         S_REPEAT: begin
            if (!i_btn) begin
               state_d = S_IDLE;
               cnt_d   = c_CNT_ZERO;
            end else if (cnt_q == c_REPEAT_LAST) begin
               rep_d   = 1'b1;
               cnt_d   = c_CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + c_CNT_ONE;
            end
         end

         default: begin
            state_d = S_LOCKOUT;
            cnt_d   = c_CNT_ZERO;
         end
      endcase

      // "Held" reflects where the press tracker is going, not where it is.
      held_d = (state_d == S_SHORT) || (state_d == S_REPEAT);
   end

   assign o_short  = short_q;
   assign o_long   = long_q;
   assign o_repeat = rep_q;
   assign o_held   = held_q;

endmodule

`default_nettype wire

// File: tb/tb_button_events.sv
// ============================================================================
//  Module      : tb_button_events
//  Description : Self-checking bench for button_events with LONG_TICKS=8,
//                REPEAT_TICKS=3, compared each cycle against a press-length
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_events;

   localparam int LT = 8;
   localparam int RT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn = 1'b0;
   logic o_short, o_long, o_repeat, o_held;

   int checks = 0;
   int errors = 0;

   // Reference model: lockout flag, press-in-progress flag, high samples
   // counted since the press was picked up.
   bit   m_locked;
   bit   m_pressing;
   int   m_len;
   logic [3:0] m_exp;   // {short, long, repeat, held}

   // Pulse tallies for per-scenario counting.
   int n_short, n_long, n_rep;

   button_events #(
      .LONG_TICKS   (LT),
      .REPEAT_TICKS (RT),
      .CNT_W        (14)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_btn    (btn),
      .o_short  (o_short),
      .o_long   (o_long),
      .o_repeat (o_repeat),
      .o_held   (o_held)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_locked   = 1'b1;
      m_pressing = 1'b0;
      m_len      = 0;
      m_exp      = 4'b0000;
   endtask

   // One rising edge of the reference model with the sampled button level.
   task automatic model_edge(input logic b);
      logic s, l, r, h;
      s = 1'b0; l = 1'b0; r = 1'b0; h = 1'b0;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_locked) begin
         if (!b) m_locked = 1'b0;
      end else if (!m_pressing) begin
         if (b) begin
            m_pressing = 1'b1;
            m_len      = 1;
            h          = 1'b1;
         end
      end else begin
         if (!b) begin
            s          = (m_len < LT);
            m_pressing = 1'b0;
            m_len      = 0;
         end else begin
            m_len = m_len + 1;
            h     = 1'b1;
            if (m_len == LT) l = 1'b1;
            else if (m_len > LT && ((m_len - LT) % RT) == 0) r = 1'b1;
         end
      end
      m_exp = {s, l, r, h};
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (short,long,repeat,held)", tag, obs, expv);
      end
   endtask

   task automatic chk_cnt(input string tag, input int obs, input int expv);
      checks++;
      assert (obs == expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic clear_tally();
      n_short = 0; n_long = 0; n_rep = 0;
   endtask

   // Drive one button sample, let the edge happen, then compare 1 time unit later.
   task automatic step(input logic b, input string tag);
      btn = b;
      @(posedge clk);
      model_edge(b);
      #1;
      chk(tag, {o_short, o_long, o_repeat, o_held}, m_exp);
      n_short += int'(o_short);
      n_long  += int'(o_long);
      n_rep   += int'(o_repeat);
   endtask

   initial begin
      int plen, gap;

      // ---- Reset with button released --------------------------------------
      btn = 1'b0;
      rst = 1'b1;
      model_reset();
      #12;
      chk("reset_state", {o_short, o_long, o_repeat, o_held}, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      // ---- Short press: 4 high samples from edge 2 -------------------------
      clear_tally();
      step(1'b0, "lockout_to_idle");
      repeat (4) step(1'b1, "short4_hold");
      step(1'b0, "short4_release");
      step(1'b0, "short4_idle");
      chk_cnt("short4_n_short", n_short, 1);
      chk_cnt("short4_n_long",  n_long,  0);

      // ---- 20-cycle hold: long plus four repeats ---------------------------
      clear_tally();
      repeat (20) step(1'b1, "hold20");
      step(1'b0, "hold20_release");
      chk_cnt("hold20_n_long",  n_long,  1);
      chk_cnt("hold20_n_rep",   n_rep,   4);
      chk_cnt("hold20_n_short", n_short, 0);

      // ---- Threshold boundary: 7 samples vs 8 samples ----------------------
      clear_tally();
      repeat (7) step(1'b1, "hold7");
      step(1'b0, "hold7_release");
      chk_cnt("hold7_n_short", n_short, 1);
      chk_cnt("hold7_n_long",  n_long,  0);
      clear_tally();
      repeat (8) step(1'b1, "hold8");
      step(1'b0, "hold8_release");
      chk_cnt("hold8_n_long",  n_long,  1);
      chk_cnt("hold8_n_short", n_short, 0);
      chk_cnt("hold8_n_rep",   n_rep,   0);

      // ---- Reset while held: lockout until release -------------------------
      btn = 1'b1;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_held_immediate", {o_short, o_long, o_repeat, o_held}, 4'b0000);
      step(1'b1, "rst_held_in_reset");
      rst = 1'b0;
      model_reset();
      clear_tally();
      repeat (30) step(1'b1, "lockout_held");
      chk_cnt("lockout_pulses", n_short + n_long + n_rep, 0);
      step(1'b0, "lockout_release");
      step(1'b1, "after_lockout_press");
      step(1'b1, "after_lockout_press");
      step(1'b0, "after_lockout_release");
      chk_cnt("after_lockout_n_short", n_short, 1);

      // ---- Async reset in the middle of REPEAT -----------------------------
      clear_tally();
      repeat (12) step(1'b1, "to_repeat");
      chk_cnt("to_repeat_n_rep", n_rep, 1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid_repeat_async_rst", {o_short, o_long, o_repeat, o_held}, 4'b0000);
      #1;
      rst = 1'b0;
      clear_tally();
      repeat (12) step(1'b1, "post_rst_held");
      chk_cnt("post_rst_pulses", n_short + n_long + n_rep, 0);
      step(1'b0, "post_rst_release");

      // ---- Alternating single-cycle presses --------------------------------
      clear_tally();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, "alt_high");
         step(1'b0, "alt_low");
      end
      chk_cnt("alt_n_short", n_short, 10);
      chk_cnt("alt_n_long",  n_long,  0);

      // ---- Randomised presses with occasional asynchronous reset -----------
      for (int i = 0; i < 60; i++) begin
         plen = int'($urandom_range(1, 16));
         gap  = int'($urandom_range(1, 3));
         for (int j = 0; j < plen; j++) begin
            step(1'b1, "rand_hold");
            if ($urandom_range(0, 63) == 0) begin
               #2;
               rst = 1'b1;
               model_reset();
               #1;
               chk("rand_async_rst", {o_short, o_long, o_repeat, o_held}, 4'b0000);
               #1;
               rst = 1'b0;
            end
         end
         for (int j = 0; j < gap; j++) step(1'b0, "rand_gap");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case something stalls the sequence.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
